// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for an APB bridge: latches the winner's
// request, drives the bridge command inputs, and times out stalled transfers.
module apb_req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [8:0] addr0,
  input  logic [8:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       transfer,
  output logic       READ_WRITE,
  output logic [8:0] write_paddr,
  output logic [8:0] read_paddr,
  output logic [7:0] write_data,
  input  logic       PENABLE,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] bridge_rdata,
  output logic [1:0] fsm_state
);

  // Handshake: a requester raises req with its fields stable; once gnt rises
  // the fields are captured and req is ignored until the single-cycle done.
  typedef enum logic [1:0] {
    ARB  = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       owner;
  logic       last;
  logic       lat_rw;
  logic [8:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] cnt;
  logic [7:0] rdata_q;
  logic       err_q;
  logic       winner;
  logic       complete;
  logic       expired;

  assign complete = PENABLE & PREADY;
  assign expired  = (cnt == 8'(TIMEOUT - 1));
  // Tie goes to whoever was not served last; a lone request always wins.
  assign winner   = (req0 & req1) ? ~last : ~req0;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB:     if (req0 | req1) state_nxt = XFER;
      XFER:    if (complete | expired) state_nxt = RESP;
      RESP:    state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ARB;
      owner     <= 1'b0;
      last      <= 1'b1;
      lat_rw    <= 1'b0;
      lat_addr  <= 9'd0;
      lat_wdata <= 8'd0;
      cnt       <= 8'd0;
      rdata_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB: begin
          if (req0 | req1) begin
            owner     <= winner;
            lat_rw    <= winner ? rw1 : rw0;
            lat_addr  <= winner ? addr1 : addr0;
            lat_wdata <= winner ? wdata1 : wdata0;
            cnt       <= 8'd0;
          end
        end
        XFER: begin
          // Completion outranks the timeout when both land on the same edge.
          if (complete) begin
            err_q <= PSLVERR;
            if (lat_rw) rdata_q <= bridge_rdata;
          end else if (expired) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP:    last <= owner;
        default: ;
      endcase
    end
  end

  assign gnt0        = (state != ARB) & ~owner;
  assign gnt1        = (state != ARB) & owner;
  assign done0       = (state == RESP) & ~owner;
  assign done1       = (state == RESP) & owner;
  assign err         = err_q;
  assign rdata       = rdata_q;
  assign transfer    = (state == XFER);
  assign READ_WRITE  = lat_rw;
  assign write_paddr = lat_addr;
  assign read_paddr  = lat_addr;
  assign write_data  = lat_wdata;
  assign fsm_state   = state;

endmodule
